register_file_2r1w: RTL and testbench
=====================================

Name: register_file_2r1w

Overview:
- Parametrised successor to the single-ported register file: one write port and two independent read ports, so the decode stage can fetch rs1 and rs2 in the same cycle.
- Synchronous reads with one-cycle latency and optional write-to-read bypass.
- Read-hold input for pipeline stalls.
- Asynchronous active-low clear of the whole array.
- Sits between decode and execute in the pipelined core.

Parameters:
- W, 32, data width in bits.
- A, 5, address width; depth is 2**A entries.
- ZERO_REG, 1, when 1, entry 0 is hardwired to zero and writes to it are dropped.
- BYPASS, 1, when 1, a same-cycle write to the address being read is forwarded to the read output (write-first); when 0, the read returns the pre-write value (read-first).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- we  input  1  write enable.
- waddr  input  A  write address.
- wdata  input  W  write data.
- re  input  1  read enable; 0 holds both read outputs (stall).
- raddr1  input  A  read port 1 address.
- raddr2  input  A  read port 2 address.
- rdata1  output  W  read port 1 data, registered.
- rdata2  output  W  read port 2 data, registered.

Behaviour:
- Reset:
  - rst_n low immediately forces all 2**A entries, rdata1 and rdata2 to 0, independent of clk.
  - While rst_n is low, writes and reads are ignored.
  - The first active edge is the first rising clk with rst_n high.
  - Reset asserted mid-write: that write is lost and the entry reads 0.
- Write:
  - On a rising edge with we=1, entry[waddr] <= wdata.
  - If ZERO_REG=1 and waddr=0, the write is dropped.
  - Writes occur regardless of re.
- Read timing:
  - On a rising edge with re=1, each port N samples raddrN.
  - rdataN presents the result after that edge and holds it until the next edge with re=1.
  - Latency is exactly 1 cycle from address to data.
- Read value for port N, in priority order:
  1. ZERO_REG=1 and raddrN=0 -> 0, even if a write to 0 is attempted.
  2. BYPASS=1, we=1, waddr=raddrN and (ZERO_REG=0 or waddr!=0) -> wdata of the same edge.
  3. Otherwise -> entry[raddrN] value before this edge's write.
- re=0:
  - rdata1 and rdata2 keep their previous values.
  - A write to the held address does not alter the held output.
  - A later edge with re=1 returns the updated entry.
- Port independence and collisions:
  - Both ports may read the same address; both return identical data.
  - Both ports may match waddr simultaneously; bypass applies to each independently.
- Array storage:
  - No reset other than rst_n.
  - Out-of-range addresses cannot occur, since depth is a full 2**A.
- Width rules:
  - No arithmetic.
  - Data passes bit-exact; addresses compare on all A bits.
- Sequencing:
  - No internal FSM beyond the storage array and the two output registers.
  - Output registers load enable = re and rst_n high.

Test Plan:
- Reset: write entries 1..31 with i*10+1 (we=1, re=0), pulse rst_n low between clocks -> rdata1/rdata2 drop to 0 without a clk edge; subsequent reads of 1..31 return 0.
- Fill/readback: write i*10+1 to entries 0..31, then read raddr1=i, raddr2=31-i with re=1 -> rdata1=i*10+1 and rdata2=(31-i)*10+1 one cycle later for i>=1; entry 0 returns 0 on both ports (ZERO_REG=1).
- Bypass: entry 5 holds 51; same edge we=1, waddr=5, wdata=0xDEADBEEF, raddr1=raddr2=5 -> BYPASS=1: both outputs 0xDEADBEEF; BYPASS=0 build: both 51, then 0xDEADBEEF on the next read.
- Zero register: we=1, waddr=0, wdata=0xFFFFFFFF, raddr1=0 same edge and next -> rdata1=0 both cycles; ZERO_REG=0 build: entry 0 returns 0xFFFFFFFF (bypassed).
- Stall: read entry 7 (=71) with re=1, then re=0 for 3 cycles while writing 0x1234 to entry 7 -> rdata1 stays 71 for 3 cycles; re=1 next edge -> 0x1234.
- Parameter sweep: W=8, A=3 instance, write all 8 entries with i+0xA0 and read via both ports -> values match, and the top address 7 is accessible.

Source files
------------

// File: rtl/register_file_2r1w.sv
// register_file_2r1w
//   Register file with one write port and two independent read ports, so the
//   decode stage can fetch both source operands in the same cycle.
//   Reads are synchronous with one cycle of latency. An optional write-first
//   bypass forwards a same-edge write to a matching read port. re=0 freezes
//   both read outputs for pipeline stalls. rst_n clears the whole array and
//   both read outputs immediately, without waiting for a clock edge.
//
// Parameters
//   W        data width in bits
//   A        address width; depth is 2**A
//   ZERO_REG 1: entry 0 reads as zero and writes to it are dropped
//   BYPASS   1: write-first forwarding; 0: read-first (pre-write value)
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low clear
//   we/waddr/wdata write port
//   re             read enable; 0 holds rdata1/rdata2
//   raddr1/raddr2  read addresses
//   rdata1/rdata2  registered read data
module register_file_2r1w #(
  parameter int W        = 32,
  parameter int A        = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [A-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic         re,
  input  logic [A-1:0] raddr1,
  input  logic [A-1:0] raddr2,
  output logic [W-1:0] rdata1,
  output logic [W-1:0] rdata2
);

  localparam int DEPTH = 2 ** A;

  // The asynchronous clear of every entry rules out block RAM, so the array
  // is built from flops, one always_ff per entry.
  logic [W-1:0] mem_reg [DEPTH];
  logic [W-1:0] rdata1_reg, rdata2_reg;
  logic [W-1:0] rdata1_next, rdata2_next;
  logic         wr_hit;

  // A write that actually lands in the array. Writes to entry 0 are dropped
  // when it is the hardwired zero register.
  assign wr_hit = we && !((ZERO_REG != 0) && (waddr == '0));

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_reg[gi] <= '0;
        end else if (wr_hit && (waddr == A'(gi))) begin
          mem_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  // Read value selection, highest priority first: zero register, then the
  // same-edge write (bypass builds only), then the stored pre-write value.
  always_comb begin
    rdata1_next = mem_reg[raddr1];
    rdata2_next = mem_reg[raddr2];
    if ((BYPASS != 0) && wr_hit && (waddr == raddr1)) rdata1_next = wdata;
    if ((BYPASS != 0) && wr_hit && (waddr == raddr2)) rdata2_next = wdata;
    if ((ZERO_REG != 0) && (raddr1 == '0)) rdata1_next = '0;
    if ((ZERO_REG != 0) && (raddr2 == '0)) rdata2_next = '0;
  end

  // Output registers load only when re is high; re=0 holds them (stall).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata1_reg <= '0;
      rdata2_reg <= '0;
    end else if (re) begin
      rdata1_reg <= rdata1_next;
      rdata2_reg <= rdata2_next;
    end
  end

  assign rdata1 = rdata1_reg;
  assign rdata2 = rdata2_reg;

endmodule

// File: tb/tb_register_file_2r1w.sv
module tb_register_file_2r1w;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        we    = 1'b0;
  logic        re    = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;

  logic [31:0] rd1, rd2;        // default build
  logic [31:0] rd1_nb, rd2_nb;  // BYPASS=0
  logic [31:0] rd1_nz, rd2_nz;  // ZERO_REG=0

  logic [2:0]  waddr8  = '0;
  logic [7:0]  wdata8  = '0;
  logic [2:0]  raddr81 = '0;
  logic [2:0]  raddr82 = '0;
  logic [7:0]  rd81, rd82;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  register_file_2r1w dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1), .rdata2(rd2)
  );

  register_file_2r1w #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_nb), .rdata2(rd2_nb)
  );

  register_file_2r1w #(.ZERO_REG(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_nz), .rdata2(rd2_nz)
  );

  register_file_2r1w #(.W(8), .A(3), .ZERO_REG(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr8), .wdata(wdata8),
    .re(re), .raddr1(raddr81), .raddr2(raddr82), .rdata1(rd81), .rdata2(rd82)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    #1 rst_n = 1'b0;
    #1;
    chk("reset_rd1", rd1, 32'd0);
    chk("reset_rd2", rd2, 32'd0);
    tick();
    rst_n = 1'b1;

    // write entries 1..31 with i*10+1, re=0
    we = 1'b1;
    for (int i = 1; i < 32; i++) begin
      waddr = 5'(i);
      wdata = 32'(i * 10 + 1);
      tick();
    end
    we = 1'b0;
    re = 1'b1; raddr1 = 5'd5; raddr2 = 5'd9;
    tick();
    chk("pre_reset_rd1", rd1, 32'd51);
    chk("pre_reset_rd2", rd2, 32'd91);

    // async reset between clocks, with a write pending across an edge
    rst_n = 1'b0;
    #2;
    chk("async_clr_rd1", rd1, 32'd0);
    chk("async_clr_rd2", rd2, 32'd0);
    we = 1'b1; waddr = 5'd3; wdata = 32'h55;
    tick();
    chk("reset_hold_rd1", rd1, 32'd0);
    we = 1'b0;
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      tick();
      chk($sformatf("post_reset_rd1[%0d]", i), rd1, 32'd0);
      chk($sformatf("post_reset_rd2[%0d]", 31 - i), rd2, 32'd0);
    end

    // ---------------- fill / readback ----------------
    re = 1'b0; we = 1'b1;
    for (int i = 0; i < 32; i++) begin
      waddr = 5'(i);
      wdata = 32'(i * 10 + 1);
      tick();
    end
    we = 1'b0; re = 1'b1;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      tick();
      chk($sformatf("fill_rd1[%0d]", i), rd1, (i == 0) ? 32'd0 : 32'(i * 10 + 1));
      chk($sformatf("fill_rd2[%0d]", 31 - i), rd2, (i == 31) ? 32'd0 : 32'((31 - i) * 10 + 1));
      chk($sformatf("fill_nz_rd1[%0d]", i), rd1_nz, 32'(i * 10 + 1));
    end

    // ---------------- bypass ----------------
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    raddr1 = 5'd5; raddr2 = 5'd5;
    tick();
    chk("byp_rd1", rd1, 32'hDEADBEEF);
    chk("byp_rd2", rd2, 32'hDEADBEEF);
    chk("byp_nz_rd1", rd1_nz, 32'hDEADBEEF);
    chk("nobyp_rd1", rd1_nb, 32'd51);
    chk("nobyp_rd2", rd2_nb, 32'd51);
    we = 1'b0;
    tick();
    chk("nobyp_next_rd1", rd1_nb, 32'hDEADBEEF);
    chk("nobyp_next_rd2", rd2_nb, 32'hDEADBEEF);

    // ---------------- zero register ----------------
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    raddr1 = 5'd0; raddr2 = 5'd6;
    tick();
    chk("zero_same_rd1", rd1, 32'd0);
    chk("zero_same_rd2", rd2, 32'd61);
    chk("zero_nz_same_rd1", rd1_nz, 32'hFFFFFFFF);
    we = 1'b0;
    tick();
    chk("zero_next_rd1", rd1, 32'd0);
    chk("zero_nb_next_rd1", rd1_nb, 32'd0);
    chk("zero_nz_next_rd1", rd1_nz, 32'hFFFFFFFF);

    // ---------------- stall ----------------
    raddr1 = 5'd7; raddr2 = 5'd3;
    tick();
    chk("stall_pre_rd1", rd1, 32'd71);
    chk("stall_pre_rd2", rd2, 32'd31);
    re = 1'b0; we = 1'b1; waddr = 5'd7; wdata = 32'h1234;
    raddr2 = 5'd8;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_rd1[%0d]", i), rd1, 32'd71);
      chk($sformatf("stall_rd2[%0d]", i), rd2, 32'd31);
      chk($sformatf("stall_nb_rd1[%0d]", i), rd1_nb, 32'd71);
    end
    we = 1'b0; re = 1'b1;
    tick();
    chk("stall_release_rd1", rd1, 32'h1234);
    chk("stall_release_rd2", rd2, 32'd81);
    chk("stall_release_nb_rd1", rd1_nb, 32'h1234);

    // ---------------- W=8, A=3 instance ----------------
    re = 1'b0; we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      waddr8 = 3'(i);
      wdata8 = 8'(i + 'hA0);
      tick();
    end
    we = 1'b0; re = 1'b1;
    for (int i = 0; i < 8; i++) begin
      raddr81 = 3'(i); raddr82 = 3'(7 - i);
      tick();
      chk($sformatf("w8_rd1[%0d]", i), {24'd0, rd81}, 32'(i + 'hA0));
      chk($sformatf("w8_rd2[%0d]", 7 - i), {24'd0, rd82}, 32'(7 - i + 'hA0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
